// File: rtl/qacc_pkg.sv
// Shared definitions for the sign-magnitude Q-format accumulator.
//
// Holds the default operand geometry (Q fractional bits, N total bits,
// LEN_W guard/count bits) and the controller state encodings, so the top
// level and anything decoding its state agree on one set of values.

package qacc_pkg;

    // Default operand geometry: Q15 fraction inside a 32-bit sign-magnitude word.
    localparam int unsigned QDef    = 15;
    localparam int unsigned NDef    = 32;
    localparam int unsigned LenWDef = 8;

    // Controller state encodings.
    localparam int unsigned StateW = 2;

    localparam logic [StateW-1:0] StIdle  = 2'd0;
    localparam logic [StateW-1:0] StAccum = 2'd1;
    localparam logic [StateW-1:0] StDone  = 2'd2;

endpackage

// File: rtl/qacc_sm_conv.sv
// Sign-magnitude <-> two's-complement conversion for the accumulator.
//
// Two independent combinational paths:
//   forward : N-bit sign-magnitude term -> (N+LEN_W)-bit two's complement.
//   inverse : (N+LEN_W)-bit two's complement -> N-bit sign-magnitude, with
//             the magnitude clamped to 2^(N-1)-1.
//
// Ports:
//   i_sm   in  N          sign-magnitude term (MSB = sign)
//   o_tc   out N+LEN_W    two's-complement image of i_sm
//   i_tc   in  N+LEN_W    two's-complement accumulator value
//   o_sm   out N          sign-magnitude image of i_tc, saturated
//   o_sat  out 1          i_tc magnitude did not fit in N-1 bits

module qacc_sm_conv #(
    parameter int unsigned N     = 32,
    parameter int unsigned LEN_W = 8
) (
    input  logic [N-1:0]       i_sm,
    output logic [N+LEN_W-1:0] o_tc,
    input  logic [N+LEN_W-1:0] i_tc,
    output logic [N-1:0]       o_sm,
    output logic               o_sat
);

    localparam int unsigned AccW = N + LEN_W;

    logic [AccW-1:0] fwd_mag;
    logic [AccW-1:0] inv_abs;
    logic            inv_neg;
    logic [N-2:0]    inv_mag;

    // Forward: negative zero maps onto zero because -0 == 0.
    always_comb begin
        fwd_mag = '0;
        fwd_mag[N-2:0] = i_sm[N-2:0];
        o_tc = i_sm[N-1] ? (~fwd_mag + 1'b1) : fwd_mag;
    end

    // Inverse: the guard bits keep the accumulator well clear of its most
    // negative value, so taking the absolute value cannot wrap.
    always_comb begin
        inv_neg = i_tc[AccW-1];
        inv_abs = inv_neg ? (~i_tc + 1'b1) : i_tc;
        o_sat   = |inv_abs[AccW-1:N-1];
        inv_mag = o_sat ? {(N-1){1'b1}} : inv_abs[N-2:0];
        // Sign bit only for a genuinely non-zero negative result.
        o_sm    = {inv_neg & (|inv_mag), inv_mag};
    end

endmodule

// File: rtl/qacc_sm.sv
// Streaming accumulator for sign-magnitude Q-format terms (e.g. the product
// stream of a Q-format multiplier).
//
// A run is started from IDLE with i_start and a term count i_len. Each term
// accepted on i_valid & o_ready is converted to a widened two's-complement
// value and added into a guard-bit accumulator. After the last term the
// block presents the saturated sign-magnitude sum on o_result with o_valid
// until the downstream handshake i_ready, then returns to IDLE. The result
// and overflow flag stay visible in IDLE until the next run starts.
//
// Ports:
//   i_clk     in  1      clock, rising edge
//   i_rst_n   in  1      asynchronous active-low reset
//   i_start   in  1      begin a run (IDLE only)
//   i_len     in  LEN_W  number of terms, sampled with i_start
//   i_valid   in  1      upstream term valid
//   i_data    in  N      term, sign-magnitude Q-format
//   i_ovr     in  1      upstream overflow flag, qualified by i_valid
//   o_ready   out 1      term accepted this cycle when i_valid is high
//   o_valid   out 1      o_result / o_ovr valid
//   i_ready   in  1      downstream accepts the result
//   o_result  out N      accumulated sum, sign-magnitude Q-format
//   o_ovr     out 1      overflow or saturation seen during the run
//   o_busy    out 1      not in IDLE

module qacc_sm
    import qacc_pkg::*;
#(
    parameter int unsigned Q     = QDef,
    parameter int unsigned N     = NDef,
    parameter int unsigned LEN_W = LenWDef
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_valid,
    input  logic [N-1:0]     i_data,
    input  logic             i_ovr,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_result,
    output logic             o_ovr,
    output logic             o_busy
);

    localparam int unsigned AccW = N + LEN_W;

    // Q only fixes where the binary point sits; sign-magnitude addition is
    // independent of it, so it is carried for documentation and sanity only.
    logic unused_q;
    assign unused_q = (Q < N);

    logic [StateW-1:0] state_q, state_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              ovr_q, ovr_d;

    logic [AccW-1:0]   term_tc;
    logic [N-1:0]      res_sm;
    logic              res_sat;
    logic              accept;

    qacc_sm_conv #(
        .N     (N),
        .LEN_W (LEN_W)
    ) u_conv (
        .i_sm  (i_data),
        .o_tc  (term_tc),
        .i_tc  (acc_q),
        .o_sm  (res_sm),
        .o_sat (res_sat)
    );

    assign accept = i_valid & (state_q == StAccum);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    acc_d   = '0;
                    ovr_d   = 1'b0;
                    cnt_d   = i_len;
                    // A zero-length run goes straight to DONE with a zero sum.
                    state_d = (i_len == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    acc_d = acc_q + term_tc;
                    cnt_d = cnt_q - 1'b1;
                    ovr_d = ovr_q | i_ovr;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    // Outputs decode straight from registered state, so a reset clears them
    // without waiting for a clock edge, and the accumulator holding its value
    // after the handshake keeps the result visible in IDLE.
    assign o_ready  = (state_q == StAccum);
    assign o_valid  = (state_q == StDone);
    assign o_busy   = (state_q != StIdle);
    assign o_result = res_sm;
    assign o_ovr    = ovr_q | res_sat;

endmodule
